// File: rtl/spi_master_port.sv
// spi_master_port: single-channel SPI master, fixed mode 0 (CPOL=0, CPHA=0).
// Sends one character of 1..MAX_CHAR bits per transfer, MSB- or LSB-first.
// MISO is captured on rising sclk and MOSI is updated on falling sclk.
// The busy time is (2L+1)*(divider+1) clock cycles: one lead half-period
// followed by 2L shift half-periods.
// Optional feature macro: SPI_AUTO_SS_EN.
//   Defined   : ss_pad_o is driven low only while a transfer is in progress.
//   Undefined : ss_pad_o = ~ss_sel at all times (manual select). It is all
//               ones while reset is high.
module spi_master_port #(
  parameter int SS_NB    = 8,
  parameter int MAX_CHAR = 32,
  parameter int DIV_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        go,
  input  logic [MAX_CHAR-1:0]         tx_data,
  input  logic [$clog2(MAX_CHAR)-1:0] char_len,
  input  logic                        lsb_first,
  input  logic [DIV_W-1:0]            divider,
  input  logic [SS_NB-1:0]            ss_sel,
  output logic                        busy,
  output logic                        done,
  output logic [MAX_CHAR-1:0]         rx_data,
  output logic [SS_NB-1:0]            ss_pad_o,
  output logic                        sclk_pad_o,
  output logic                        mosi_pad_o,
  input  logic                        miso_pad_o
);

  // The length register is one bit wider than char_len so that it can hold MAX_CHAR.
  localparam int LEN_W = $clog2(MAX_CHAR) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    bit_cnt;
  logic                lsb_q;
  logic [MAX_CHAR-1:0] tx_sr;
  logic [MAX_CHAR-1:0] rx_sr;

  logic [LEN_W-1:0]    len_in;
  logic [MAX_CHAR-1:0] tx_aligned;
  logic                first_bit;
  logic                tick;
  logic [MAX_CHAR-1:0] tx_next;
  logic [MAX_CHAR-1:0] rx_next;

  // Next-value helpers: length decode, alignment of the transmit word, shift steps.
  always_comb begin
    // NOTE: each signal gets a default first, so no path through the block can infer a latch.
    len_in     = '0;
    tx_aligned = '0;
    first_bit  = 1'b0;
    tick       = 1'b0;
    tx_next    = '0;
    rx_next    = '0;

    len_in = (char_len == '0) ? LEN_W'(MAX_CHAR) : {1'b0, char_len};
    // For MSB-first, bit L-1 is moved up to the top of the register so that
    // the shift direction and the bit taken do not depend on L.
    tx_aligned = lsb_first ? tx_data : (tx_data << (LEN_W'(MAX_CHAR) - len_in));
    first_bit  = lsb_first ? tx_aligned[0] : tx_aligned[MAX_CHAR-1];

    tick    = (div_cnt == div_q);
    tx_next = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
    // LSB-first puts each new bit at position L-1 and shifts right.
    // After L bits the first received bit is in bit 0 and the upper bits stay zero.
    rx_next = lsb_q ? ((rx_sr >> 1) |
                       ({{(MAX_CHAR-1){1'b0}}, miso_pad_o} << (len_q - LEN_W'(1))))
                    : {rx_sr[MAX_CHAR-2:0], miso_pad_o};
  end

  // Transfer FSM: all state, counters and pad outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the reset is synchronous. All state is cleared, including the shift registers,
      // so an aborted transfer leaves no stale data behind.
      state      <= ST_IDLE;
      div_q      <= '0;
      div_cnt    <= '0;
      len_q      <= '0;
      bit_cnt    <= '0;
      lsb_q      <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_data    <= '0;
      sclk_pad_o <= 1'b0;
      mosi_pad_o <= 1'b0;
`ifdef SPI_AUTO_SS_EN
      ss_pad_o   <= '1;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every branch reads the values from before this edge.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state      <= ST_LEAD;
            busy       <= 1'b1;
            div_q      <= divider;
            div_cnt    <= '0;
            len_q      <= len_in;
            bit_cnt    <= '0;
            lsb_q      <= lsb_first;
            tx_sr      <= tx_aligned;
            rx_sr      <= '0;
            sclk_pad_o <= 1'b0;
            mosi_pad_o <= first_bit;
`ifdef SPI_AUTO_SS_EN
            ss_pad_o   <= ~ss_sel;
`endif
          end
        end

        ST_LEAD: begin
          if (tick) begin
            div_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            if (!sclk_pad_o) begin
              sclk_pad_o <= 1'b1;
              rx_sr      <= rx_next;
              bit_cnt    <= bit_cnt + LEN_W'(1);
            end else begin
              sclk_pad_o <= 1'b0;
              if (bit_cnt == len_q) begin
                // This is the falling edge after the last bit. MOSI keeps its last value.
                state   <= ST_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                rx_data <= rx_sr;
`ifdef SPI_AUTO_SS_EN
                ss_pad_o <= '1;
`endif
              end else begin
                tx_sr      <= tx_next;
                mosi_pad_o <= lsb_q ? tx_next[0] : tx_next[MAX_CHAR-1];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef SPI_AUTO_SS_EN
  // Manual select: the selects follow the request directly, and reset forces them inactive.
  assign ss_pad_o = reset ? {SS_NB{1'b1}} : ~ss_sel;
`endif

endmodule

// File: tb/tb_spi_master_port.sv
// tb_spi_master_port: randomized self-checking bench for spi_master_port.
// Expected MOSI order, received word and timing are computed from the
// transfer rules with plain arithmetic, not from the RTL structure.
module tb_spi_master_port;

  localparam int SS_NB    = 8;
  localparam int MAX_CHAR = 32;
  localparam int DIV_W    = 16;

  logic                clock = 1'b0;
  logic                reset;
  logic                go;
  logic [MAX_CHAR-1:0] tx_data;
  logic [4:0]          char_len;
  logic                lsb_first;
  logic [DIV_W-1:0]    divider;
  logic [SS_NB-1:0]    ss_sel;
  logic                busy;
  logic                done;
  logic [MAX_CHAR-1:0] rx_data;
  logic [SS_NB-1:0]    ss_pad_o;
  logic                sclk_pad_o;
  logic                mosi_pad_o;
  logic                miso_pad_o;

  logic                miso_drv;
  logic                loopback;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  assign miso_pad_o = loopback ? mosi_pad_o : miso_drv;

  spi_master_port #(
    .SS_NB(SS_NB), .MAX_CHAR(MAX_CHAR), .DIV_W(DIV_W)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .tx_data(tx_data),
    .char_len(char_len), .lsb_first(lsb_first), .divider(divider),
    .ss_sel(ss_sel), .busy(busy), .done(done), .rx_data(rx_data),
    .ss_pad_o(ss_pad_o), .sclk_pad_o(sclk_pad_o), .mosi_pad_o(mosi_pad_o),
    .miso_pad_o(miso_pad_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Select level expected while a transfer is in progress.
  function automatic logic [SS_NB-1:0] ss_busy_exp(input logic [SS_NB-1:0] latched);
`ifdef SPI_AUTO_SS_EN
    return ~latched;
`else
    return ~ss_sel;
`endif
  endfunction

  // Select level expected while idle.
  function automatic logic [SS_NB-1:0] ss_idle_exp();
`ifdef SPI_AUTO_SS_EN
    return '1;
`else
    return ~ss_sel;
`endif
  endfunction

  task automatic scramble_inputs();
    tx_data   = $urandom;
    char_len  = 5'($urandom);
    lsb_first = 1'($urandom);
    divider   = DIV_W'($urandom);
    ss_sel    = SS_NB'($urandom);
  endtask

  // Runs one transfer and checks it against the model.
  // resp_tm holds the slave reply in time order: bit i is the i-th bit sent on MISO.
  // go_again_at >= 0 asserts go again, with new data, at that busy cycle.
  task automatic run_transfer(input logic [31:0] tx, input int clen, input logic lsb,
                              input int div, input logic [7:0] ss, input logic loop,
                              input logic [31:0] resp_tm, input int go_again_at);
    int          len;
    int          half;
    int          budget;
    int          cyc;
    int          rises;
    int          busy_cyc;
    int          ss_bad;
    int          period_bad;
    int          first_rise;
    int          last_rise;
    logic        prev_sclk;
    logic [31:0] exp_mosi;
    logic [31:0] got_mosi;
    logic [63:0] exp_rx;
    logic [63:0] mask;

    len  = (clen == 0) ? 32 : clen;
    half = div + 1;
    mask = (64'd1 << len) - 64'd1;
    exp_mosi = '0;
    exp_rx   = '0;
    for (int i = 0; i < len; i++) begin
      exp_mosi[i] = lsb ? tx[i] : tx[len-1-i];
      if (!loop) begin
        if (lsb) exp_rx[i] = resp_tm[i];
        else     exp_rx[len-1-i] = resp_tm[i];
      end
    end
    if (loop) exp_rx = {32'd0, tx} & mask;

    @(negedge clock);
    tx_data   = tx;
    char_len  = 5'(clen);
    lsb_first = lsb;
    divider   = DIV_W'(div);
    ss_sel    = ss;
    loopback  = loop;
    miso_drv  = resp_tm[0];
    go        = 1'b1;

    @(negedge clock);
    go = 1'b0;
    check("busy_start", 64'(busy), 64'd1);
    check("mosi_first", 64'(mosi_pad_o), 64'(exp_mosi[0]));

    cyc = 0; rises = 0; busy_cyc = 0; ss_bad = 0; period_bad = 0;
    first_rise = -1; last_rise = 0; prev_sclk = 1'b0; got_mosi = '0;
    budget = (2 * len + 1) * half + 10;
    while (!done && cyc < budget) begin
      if (busy) busy_cyc++;
      if (ss_pad_o !== ss_busy_exp(ss)) ss_bad++;
      if (sclk_pad_o && !prev_sclk) begin
        if (rises < 32) got_mosi[rises] = mosi_pad_o;
        if (rises == 0) first_rise = cyc;
        else if (cyc - last_rise != 2 * half) period_bad++;
        last_rise = cyc;
        rises++;
        miso_drv = (rises < 32) ? resp_tm[rises] : 1'b0;
      end
      prev_sclk = sclk_pad_o;
      scramble_inputs();
      go = (cyc == go_again_at);
      @(negedge clock);
      cyc++;
    end

    if (!done) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("done_busy", 64'(busy), 64'd0);
      check("done_sclk", 64'(sclk_pad_o), 64'd0);
      check("done_ss", 64'(ss_pad_o), 64'(ss_idle_exp()));
      check("done_mosi_hold", 64'(mosi_pad_o), 64'(exp_mosi[len-1]));
      check("rx_data", 64'(rx_data), exp_rx);
      check("busy_cycles", 64'(busy_cyc), 64'((2 * len + 1) * half));
      check("rise_count", 64'(rises), 64'(len));
      check("first_rise", 64'(first_rise), 64'(2 * half));
      check("sclk_period", 64'(period_bad), 64'd0);
      check("mosi_seq", 64'(got_mosi), 64'(exp_mosi));
      check("ss_while_busy", 64'(ss_bad), 64'd0);
    end

    // A go in the done cycle must be ignored.
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    check("go_in_done", 64'(busy), 64'd0);
    check("done_width", 64'(done), 64'd0);

    if (go_again_at >= 0) begin
      int extra_done = 0;
      int extra_busy = 0;
      for (int i = 0; i < 3 * half + 4; i++) begin
        @(negedge clock);
        if (done) extra_done++;
        if (busy) extra_busy++;
      end
      check("go_busy_no_done", 64'(extra_done), 64'd0);
      check("go_busy_no_busy", 64'(extra_busy), 64'd0);
    end
  endtask

  // Starts a transfer, applies reset after the third rising sclk edge, and checks the abort.
  task automatic reset_mid_transfer();
    int   rises;
    int   cyc;
    int   done_seen;
    logic prev_sclk;

    @(negedge clock);
    tx_data = 32'h0000_00C3; char_len = 5'd8; lsb_first = 1'b0;
    divider = 16'd1; ss_sel = 8'h04; loopback = 1'b1; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    rises = 0; cyc = 0; done_seen = 0; prev_sclk = 1'b0;
    while (rises < 3 && cyc < 100) begin
      if (sclk_pad_o && !prev_sclk) rises++;
      prev_sclk = sclk_pad_o;
      if (rises < 3) begin
        @(negedge clock);
        cyc++;
      end
    end
    check("abort_reached_bit3", 64'(rises), 64'd3);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ss", 64'(ss_pad_o), 64'hFF);
    check("abort_sclk", 64'(sclk_pad_o), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_mosi", 64'(mosi_pad_o), 64'd0);
    check("abort_rx", 64'(rx_data), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || busy) done_seen++;
    end
    check("abort_quiet", 64'(done_seen), 64'd0);
  endtask

  initial begin
    int idle_sclk;
    int idle_done;
    int idle_ss;

    reset = 1'b1; go = 1'b0; tx_data = '0; char_len = '0; lsb_first = 1'b0;
    divider = '0; ss_sel = '0; miso_drv = 1'b0; loopback = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rx", 64'(rx_data), 64'd0);
    check("rst_ss", 64'(ss_pad_o), 64'hFF);
    check("rst_sclk", 64'(sclk_pad_o), 64'd0);
    check("rst_mosi", 64'(mosi_pad_o), 64'd0);
    reset = 1'b0;

    // Idle levels: no go for 100 cycles.
    ss_sel = 8'h5A;
    idle_sclk = 0; idle_done = 0; idle_ss = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sclk_pad_o) idle_sclk++;
      if (done) idle_done++;
      if (ss_pad_o !== ss_idle_exp()) idle_ss++;
    end
    check("idle_sclk", 64'(idle_sclk), 64'd0);
    check("idle_done", 64'(idle_done), 64'd0);
    check("idle_ss", 64'(idle_ss), 64'd0);

    // Basic transfer: 0xA5 out, slave replies 0x3C (MSB first in time).
    run_transfer(32'hA5, 8, 1'b0, 1, 8'h01, 1'b0, 32'h0000_003C, -1);
    // LSB-first: time-order reply 1,0,0,0.
    run_transfer(32'h01, 4, 1'b1, 2, 8'h02, 1'b0, 32'h0000_0001, -1);
    // Full length with the fastest clock, in loopback.
    run_transfer(32'hDEAD_BEEF, 0, 1'b0, 0, 8'h80, 1'b1, 32'h0, -1);
    // A second go while busy is ignored.
    run_transfer(32'h5A, 8, 1'b0, 2, 8'h10, 1'b0, 32'h0000_00B6, 10);
    // Single-bit characters in both orders.
    run_transfer(32'h1, 1, 1'b0, 0, 8'h01, 1'b0, 32'h1, -1);
    run_transfer(32'h0, 1, 1'b1, 3, 8'h01, 1'b0, 32'h1, -1);

    reset_mid_transfer();
    run_transfer(32'h0000_9C3E, 16, 1'b1, 1, 8'h08, 1'b0, 32'h0000_71A4, -1);

    for (int t = 0; t < 20; t++) begin
      run_transfer($urandom, int'($urandom_range(0, 31)), 1'($urandom),
                   int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom),
                   $urandom, (t % 5 == 0) ? 6 : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
